// File: rtl/ysyx_23060077_rd_arbiter_if.sv
// Signal bundle between the read arbiter, its two requesters and the AXI read channel.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface ysyx_23060077_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ic_valid_i;
   logic [ADDR_W-1:0] ic_addr_i;
   logic [7:0]        ic_len_i;
   logic              ic_ready_o;
   logic [DATA_W-1:0] ic_data_o;
   logic              ic_last_o;

   logic              ls_valid_i;
   logic [ADDR_W-1:0] ls_addr_i;
   logic [7:0]        ls_len_i;
   logic              ls_ready_o;
   logic [DATA_W-1:0] ls_data_o;
   logic              ls_last_o;

   logic              arvalid_o;
   logic [ADDR_W-1:0] araddr_o;
   logic [7:0]        arlen_o;
   logic              arready_i;

   logic              rvalid_i;
   logic [DATA_W-1:0] rdata_i;
   logic [1:0]        rresp_i;
   logic              rlast_i;
   logic              rready_o;

   logic              err_o;

   modport master (
      input  ic_valid_i, ic_addr_i, ic_len_i,
      output ic_ready_o, ic_data_o, ic_last_o,
      input  ls_valid_i, ls_addr_i, ls_len_i,
      output ls_ready_o, ls_data_o, ls_last_o,
      output arvalid_o, araddr_o, arlen_o,
      input  arready_i,
      input  rvalid_i, rdata_i, rresp_i, rlast_i,
      output rready_o,
      output err_o
   );

   modport slave (
      output ic_valid_i, ic_addr_i, ic_len_i,
      input  ic_ready_o, ic_data_o, ic_last_o,
      output ls_valid_i, ls_addr_i, ls_len_i,
      input  ls_ready_o, ls_data_o, ls_last_o,
      input  arvalid_o, araddr_o, arlen_o,
      output arready_i,
      output rvalid_i, rdata_i, rresp_i, rlast_i,
      input  rready_o,
      input  err_o
   );
endinterface

// File: rtl/ysyx_23060077_rd_arbiter.sv
// Round-robin read arbiter sharing one AXI read channel between the Icache and the LSU.
// One burst in flight at a time; R beats are steered combinationally to the granted requester.
module ysyx_23060077_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   ysyx_23060077_rd_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

   state_e            state_q, state_d;
   logic              grant_ls_q, grant_ls_d;
   logic              last_ls_q, last_ls_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        count_q, count_d;
   logic              over_q, over_d;
   logic              err_q, err_d;
   logic              pick_ls_s, arvalid_s, rready_s, fwd_s;

   // LSU wins when it asks alone, or when both ask and the Icache was served last.
   assign pick_ls_s = bus.ls_valid_i & (~bus.ic_valid_i | ~last_ls_q);

   // State, grant bookkeeping, latched request and beat counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_ls_q <= 1'b0;
         last_ls_q  <= 1'b0;
         addr_q     <= {ADDR_W{1'b0}};
         len_q      <= 8'd0;
         count_q    <= 8'd0;
         over_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_ls_q <= grant_ls_d;
         last_ls_q  <= last_ls_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         count_q    <= count_d;
         over_q     <= over_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic and per-state channel controls.
   always_comb begin
      state_d    = state_q;
      grant_ls_d = grant_ls_q;
      last_ls_d  = last_ls_q;
      addr_d     = addr_q;
      len_d      = len_q;
      count_d    = count_q;
      over_d     = over_q;
      err_d      = 1'b0;
      arvalid_s  = 1'b0;
      rready_s   = 1'b0;
      fwd_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ic_valid_i | bus.ls_valid_i) begin
               grant_ls_d = pick_ls_s;
               addr_d     = pick_ls_s ? bus.ls_addr_i : bus.ic_addr_i;
               len_d      = pick_ls_s ? bus.ls_len_i : bus.ic_len_i;
               state_d    = ADDR;
            end else begin
               state_d    = IDLE;
            end
         end
         ADDR: begin
            arvalid_s = 1'b1;
            if (bus.arready_i) begin
               state_d = DATA;
               count_d = 8'd0;
               over_d  = 1'b0;
            end else begin
               state_d = ADDR;
            end
         end
         DATA: begin
            rready_s = 1'b1;
            if (bus.rvalid_i) begin
               // Beats past len+1 are swallowed until rlast shows up.
               fwd_s = ~over_q;
               err_d = (bus.rresp_i != 2'b00) | (bus.rlast_i & (count_q != len_q));
               if (!over_q) begin
                  count_d = count_q + 8'd1;
                  over_d  = (count_q == len_q) & ~bus.rlast_i;
               end else begin
                  count_d = count_q;
               end
               if (bus.rlast_i) begin
                  state_d   = IDLE;
                  last_ls_d = grant_ls_q;
               end else begin
                  state_d   = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.arvalid_o  = arvalid_s;
   assign bus.araddr_o   = addr_q;
   assign bus.arlen_o    = len_q;
   assign bus.rready_o   = rready_s;
   assign bus.err_o      = err_q;

   assign bus.ic_ready_o = fwd_s & ~grant_ls_q;
   assign bus.ic_data_o  = bus.ic_ready_o ? bus.rdata_i : {DATA_W{1'b0}};
   assign bus.ic_last_o  = bus.ic_ready_o & bus.rlast_i;
   assign bus.ls_ready_o = fwd_s & grant_ls_q;
   assign bus.ls_data_o  = bus.ls_ready_o ? bus.rdata_i : {DATA_W{1'b0}};
   assign bus.ls_last_o  = bus.ls_ready_o & bus.rlast_i;
endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Directed self-checking bench for the read arbiter: stimulus is driven and sampled on the
// falling clock edge, and every expected value is hand-computed in the test tasks.
module tb_ysyx_23060077_rd_arbiter;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   ysyx_23060077_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   ysyx_23060077_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   int          ar_cnt, ar_cycles;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic        overlap, post_err, post_idle;
   logic        ob_ic_rdy [8];
   logic        ob_ls_rdy [8];
   logic        ob_ic_last [8];
   logic        ob_ls_last [8];
   logic        ob_err [8];
   logic        ob_rready [8];
   logic [31:0] ob_ic_data [8];

   // Slave-side model: waits ar_wait cycles before arready, sends nbeats beats, rlast on last_beat.
   task automatic serve(input int ar_wait, input int nbeats, input int last_beat,
                        input logic [1:0] resp0, input logic [1:0] drop);
      ar_cnt = 0; ar_cycles = 0; overlap = 1'b0; ar_addr = 32'h0; ar_len = 8'h0;
      for (int i = 0; i <= ar_wait; i++) begin
         @(negedge clock);
         bus.arready_i = (i == ar_wait);
         #1;
         overlap = overlap | (bus.arvalid_o & bus.rready_o);
         if (bus.arvalid_o) begin
            ar_cycles++; ar_addr = bus.araddr_o; ar_len = bus.arlen_o;
            if (bus.arready_i) ar_cnt++;
         end
      end
      for (int b = 0; b < nbeats; b++) begin
         @(negedge clock);
         bus.arready_i = 1'b0;
         bus.rvalid_i  = 1'b1;
         bus.rdata_i   = 32'hD000_0000 + 32'(b);
         bus.rlast_i   = (b == last_beat);
         bus.rresp_i   = (b == 0) ? resp0 : 2'b00;
         #1;
         overlap       = overlap | (bus.arvalid_o & bus.rready_o);
         if (bus.arvalid_o) ar_cycles++;
         ob_ic_rdy[b]  = bus.ic_ready_o;  ob_ls_rdy[b]  = bus.ls_ready_o;
         ob_ic_last[b] = bus.ic_last_o;   ob_ls_last[b] = bus.ls_last_o;
         ob_err[b]     = bus.err_o;       ob_rready[b]  = bus.rready_o;
         ob_ic_data[b] = bus.ic_data_o;
      end
      @(negedge clock);
      bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0; bus.rresp_i = 2'b00;
      if (drop[0]) bus.ic_valid_i = 1'b0;
      if (drop[1]) bus.ls_valid_i = 1'b0;
      #1;
      post_err  = bus.err_o;
      post_idle = !bus.arvalid_o && !bus.rready_o;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      checks++; if ({bus.arvalid_o, bus.rready_o, bus.ic_ready_o, bus.ls_ready_o, bus.ic_last_o, bus.ls_last_o, bus.err_o} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {bus.arvalid_o, bus.rready_o, bus.ic_ready_o, bus.ls_ready_o, bus.ic_last_o, bus.ls_last_o, bus.err_o}); end
      checks++; if ({bus.araddr_o, bus.arlen_o} !== 40'h0) begin
         errors++; $display("FAIL reset_ar: got %h/%h expected 0/0", bus.araddr_o, bus.arlen_o); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_both_after_reset();
      bus.ic_valid_i = 1'b1; bus.ic_addr_i = 32'h1000_0000; bus.ic_len_i = 8'd0;
      bus.ls_valid_i = 1'b1; bus.ls_addr_i = 32'h2000_0000; bus.ls_len_i = 8'd0;
      serve(0, 1, 0, 2'b00, 2'b10);
      checks++; if (ar_addr !== 32'h2000_0000 || ob_ls_rdy[0] !== 1'b1 || ob_ic_rdy[0] !== 1'b0) begin
         errors++; $display("FAIL first_grant_lsu: got addr %h ls %b ic %b expected 20000000 1 0", ar_addr, ob_ls_rdy[0], ob_ic_rdy[0]); end
      checks++; if (post_idle !== 1'b1) begin
         errors++; $display("FAIL first_idle: got %b expected 1", post_idle); end
      serve(0, 1, 0, 2'b00, 2'b01);
      checks++; if (ar_cnt !== 1 || ar_addr !== 32'h1000_0000 || ob_ic_rdy[0] !== 1'b1 || ob_ls_rdy[0] !== 1'b0) begin
         errors++; $display("FAIL second_grant_ic: got ar %0d addr %h ic %b ls %b expected 1 10000000 1 0", ar_cnt, ar_addr, ob_ic_rdy[0], ob_ls_rdy[0]); end
   endtask

   task automatic test_alternate();
      logic exp_ls;
      @(negedge clock);
      bus.ic_valid_i = 1'b1; bus.ic_addr_i = 32'h1111_0000; bus.ic_len_i = 8'd1;
      bus.ls_valid_i = 1'b1; bus.ls_addr_i = 32'h2222_0000; bus.ls_len_i = 8'd1;
      for (int k = 0; k < 4; k++) begin
         exp_ls = (k % 2 == 0);
         serve(1, 2, 1, 2'b00, (k == 3) ? 2'b11 : 2'b00);
         checks++; if (ob_ls_rdy[0] !== exp_ls || ob_ic_rdy[0] !== !exp_ls || ar_addr !== (exp_ls ? 32'h2222_0000 : 32'h1111_0000)) begin
            errors++; $display("FAIL alternate_%0d: got ls %b ic %b addr %h expected ls %b", k, ob_ls_rdy[0], ob_ic_rdy[0], ar_addr, exp_ls); end
         checks++; if (ob_ls_last[1] !== exp_ls || ob_ic_last[1] !== !exp_ls || ar_cnt !== 1) begin
            errors++; $display("FAIL alternate_last_%0d: got ls %b ic %b ar %0d expected ls %b ar 1", k, ob_ls_last[1], ob_ic_last[1], ar_cnt, exp_ls); end
      end
   endtask

   task automatic test_icache_basic();
      int n_ic, n_ls, n_err;
      logic [3:0] lasts;
      @(negedge clock);
      bus.ic_valid_i = 1'b1; bus.ic_addr_i = 32'h3000_0100; bus.ic_len_i = 8'd3;
      serve(2, 4, 3, 2'b00, 2'b01);
      n_ic = 0; n_ls = 0; n_err = 0; lasts = 4'b0;
      for (int b = 0; b < 4; b++) begin
         n_ic += int'(ob_ic_rdy[b]); n_ls += int'(ob_ls_rdy[b]) + int'(ob_ls_last[b]);
         n_err += int'(ob_err[b]) + int'(!ob_rready[b]); lasts[b] = ob_ic_last[b];
      end
      checks++; if (ar_cnt !== 1 || ar_cycles !== 3) begin
         errors++; $display("FAIL ic_ar_count: got hs %0d cycles %0d expected 1 3", ar_cnt, ar_cycles); end
      checks++; if (ar_addr !== 32'h3000_0100 || ar_len !== 8'd3) begin
         errors++; $display("FAIL ic_ar_fields: got %h/%0d expected 30000100/3", ar_addr, ar_len); end
      checks++; if (n_ic !== 4 || n_ls !== 0) begin
         errors++; $display("FAIL ic_beats: got ic %0d ls %0d expected 4 0", n_ic, n_ls); end
      checks++; if (lasts !== 4'b1000) begin
         errors++; $display("FAIL ic_last_pos: got %b expected 1000", lasts); end
      checks++; if (ob_ic_data[2] !== 32'hD000_0002) begin
         errors++; $display("FAIL ic_data: got %h expected d0000002", ob_ic_data[2]); end
      checks++; if (overlap !== 1'b0 || n_err !== 0 || post_err !== 1'b0 || post_idle !== 1'b1) begin
         errors++; $display("FAIL ic_clean: got overlap %b err/rready %0d post_err %b idle %b expected 0 0 0 1", overlap, n_err, post_err, post_idle); end
   endtask

   task automatic test_lsu_err();
      @(negedge clock);
      bus.ls_valid_i = 1'b1; bus.ls_addr_i = 32'h2000_0040; bus.ls_len_i = 8'd0;
      serve(0, 1, 0, 2'b10, 2'b10);
      checks++; if (ob_ls_rdy[0] !== 1'b1 || ob_ls_last[0] !== 1'b1 || ob_err[0] !== 1'b0) begin
         errors++; $display("FAIL lsu_err_beat: got rdy %b last %b err %b expected 1 1 0", ob_ls_rdy[0], ob_ls_last[0], ob_err[0]); end
      checks++; if (post_err !== 1'b1 || post_idle !== 1'b1) begin
         errors++; $display("FAIL lsu_err_pulse: got err %b idle %b expected 1 1", post_err, post_idle); end
      @(negedge clock); #1;
      checks++; if (bus.err_o !== 1'b0) begin
         errors++; $display("FAIL lsu_err_width: got %b expected 0", bus.err_o); end
   endtask

   task automatic test_early_last();
      @(negedge clock);
      bus.ic_valid_i = 1'b1; bus.ic_addr_i = 32'h3000_0200; bus.ic_len_i = 8'd3;
      serve(0, 2, 1, 2'b00, 2'b01);
      checks++; if (ob_ic_last[1] !== 1'b1 || ob_err[1] !== 1'b0 || post_err !== 1'b1 || post_idle !== 1'b1) begin
         errors++; $display("FAIL early_last: got last %b err %b post_err %b idle %b expected 1 0 1 1", ob_ic_last[1], ob_err[1], post_err, post_idle); end
      @(negedge clock);
      bus.ls_valid_i = 1'b1; bus.ls_addr_i = 32'h2000_0080; bus.ls_len_i = 8'd0;
      serve(0, 1, 0, 2'b00, 2'b10);
      checks++; if (ar_cnt !== 1 || ar_addr !== 32'h2000_0080 || ob_ls_last[0] !== 1'b1 || post_err !== 1'b0) begin
         errors++; $display("FAIL after_early: got ar %0d addr %h last %b err %b expected 1 20000080 1 0", ar_cnt, ar_addr, ob_ls_last[0], post_err); end
   endtask

   task automatic test_overrun();
      @(negedge clock);
      bus.ic_valid_i = 1'b1; bus.ic_addr_i = 32'h3000_0300; bus.ic_len_i = 8'd1;
      serve(0, 3, 2, 2'b00, 2'b01);
      checks++; if ({ob_ic_rdy[0], ob_ic_rdy[1], ob_ic_rdy[2], ob_ic_last[2]} !== 4'b1100) begin
         errors++; $display("FAIL overrun_fwd: got %b expected 1100", {ob_ic_rdy[0], ob_ic_rdy[1], ob_ic_rdy[2], ob_ic_last[2]}); end
      checks++; if (post_err !== 1'b1 || post_idle !== 1'b1) begin
         errors++; $display("FAIL overrun_end: got err %b idle %b expected 1 1", post_err, post_idle); end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      bus.ic_valid_i = 1'b1; bus.ic_addr_i = 32'h3000_0400; bus.ic_len_i = 8'd3;
      serve(0, 1, 9, 2'b00, 2'b01);
      checks++; if (ob_ic_rdy[0] !== 1'b1 || post_idle !== 1'b0) begin
         errors++; $display("FAIL mid_before: got rdy %b idle %b expected 1 0", ob_ic_rdy[0], post_idle); end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.rvalid_i = 1'b1; bus.rdata_i = 32'hD000_0001; bus.rlast_i = 1'b0;
      #1;
      checks++; if ({bus.arvalid_o, bus.rready_o, bus.ic_ready_o, bus.ls_ready_o, bus.ic_last_o, bus.ls_last_o, bus.err_o} !== 7'b0 || bus.araddr_o !== 32'h0 || bus.arlen_o !== 8'd0) begin
         errors++; $display("FAIL mid_reset: got ctrl %b addr %h len %0d expected 0 0 0", {bus.arvalid_o, bus.rready_o, bus.ic_ready_o, bus.ls_ready_o, bus.ic_last_o, bus.ls_last_o, bus.err_o}, bus.araddr_o, bus.arlen_o); end
      @(negedge clock);
      bus.rlast_i = 1'b1;
      #1;
      checks++; if (bus.rready_o !== 1'b0 || bus.ic_ready_o !== 1'b0 || bus.ic_last_o !== 1'b0) begin
         errors++; $display("FAIL mid_ignore: got rready %b rdy %b last %b expected 0 0 0", bus.rready_o, bus.ic_ready_o, bus.ic_last_o); end
      @(negedge clock);
      bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0;
      #1;
      checks++; if (bus.err_o !== 1'b0 || bus.arvalid_o !== 1'b0) begin
         errors++; $display("FAIL mid_quiet: got err %b arvalid %b expected 0 0", bus.err_o, bus.arvalid_o); end
   endtask

   initial begin
      reset = 1'b1;
      bus.ic_valid_i = 1'b0; bus.ic_addr_i = 32'h0; bus.ic_len_i = 8'd0;
      bus.ls_valid_i = 1'b0; bus.ls_addr_i = 32'h0; bus.ls_len_i = 8'd0;
      bus.arready_i  = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = 32'h0;
      bus.rresp_i    = 2'b00; bus.rlast_i = 1'b0;
      test_reset();
      test_both_after_reset();
      test_alternate();
      test_icache_basic();
      test_lsu_err();
      test_early_last();
      test_overrun();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ysyx_23060077_rd_arbiter.md
YSYX_23060077_RD_ARBITER -- requirements
Module: ysyx_23060077_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, AXI read address width.
REQ-002 SHALL have parameter DATA_W, 32, read data width.
REQ-003 SHALL have ports clock (in, 1, clock) and reset (in, 1, reset); reset is synchronous, active-high; all state changes on posedge clock.
REQ-004 SHALL have Icache requester port: ic_valid_i (in, 1, request held until last beat); ic_addr_i (in, ADDR_W, start address); ic_len_i (in, 8, AXI beats-1); ic_ready_o (out, 1, data beat valid); ic_data_o (out, DATA_W, beat data); ic_last_o (out, 1, final beat).
REQ-005 SHALL have LSU requester port with the same signals, prefix ls_, same widths and meaning.
REQ-006 SHALL have AXI AR master port: arvalid_o (out, 1), araddr_o (out, ADDR_W), arlen_o (out, 8), arready_i (in, 1).
REQ-007 SHALL have AXI R master port: rvalid_i (in, 1), rdata_i (in, DATA_W), rresp_i (in, 2), rlast_i (in, 1), rready_o (out, 1).
REQ-008 SHALL have err_o (out, 1): one-cycle error pulse.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-010 In IDLE: if any *_valid_i is high, SHALL latch the winner as grant, latch its addr and len, and go to ADDR the next cycle; otherwise SHALL stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; the first arbitration after reset favours LSU.
REQ-012 In ADDR: SHALL drive arvalid_o=1 with latched araddr_o/arlen_o held stable; on arready_i=1, SHALL go to DATA.
REQ-013 In DATA: SHALL drive rready_o=1. On each rvalid_i=1 cycle, SHALL route the beat combinationally to the granted port only: *_ready_o=1, *_data_o=rdata_i, *_last_o=rlast_i.
REQ-014 The non-granted port SHALL see ready_o=0 and last_o=0 in all states.
REQ-015 SHALL count accepted beats in an 8-bit counter, cleared on entry to DATA.
REQ-016 On rvalid_i & rlast_i, SHALL return to IDLE the next cycle and record the grant as last-granted.
REQ-017 Back-to-back requests SHALL cost exactly one IDLE cycle between transactions.
REQ-018 Requester valid deasserting mid-transaction SHALL NOT abort the transaction; all remaining beats SHALL still be consumed.
REQ-019 err_o SHALL pulse the cycle after either error condition: a beat with rresp_i != 0, or rlast_i arriving when count != latched len.
REQ-020 If rlast_i arrives early, SHALL still end the transaction on that beat.
REQ-021 If count reaches len+1 without rlast_i, SHALL keep waiting for rlast_i and SHALL NOT forward the extra beats (their ready_o=0).
REQ-022 Minimum latency, request valid to AR handshake: 1 cycle (IDLE->ADDR register stage).
REQ-023 The arbiter SHALL add no cycles on the R path.
REQ-024 rready_o and arvalid_o SHALL never be high in the same cycle.

Reset
REQ-025 On reset: state=IDLE; arvalid_o=0; rready_o=0; all *_ready_o=0; all *_last_o=0; err_o=0; count=0; last-granted=Icache; araddr_o=0; arlen_o=0.
REQ-026 Reset mid-transaction SHALL drop to IDLE without completing outstanding beats.
REQ-027 After reset, beats still arriving SHALL be ignored in IDLE (rready_o=0).

Verification
REQ-028 Icache only, addr 0x3000_0100, len 3, arready after 2 cycles -> exactly one AR (araddr 0x3000_0100, arlen 3); 4 ic_ready_o pulses; ic_last_o on 4th; ls_ready_o stays 0.
REQ-029 Both valid in the same cycle after reset -> LSU granted first; Icache granted on the next transaction after one IDLE cycle.
REQ-030 Both continuously valid for 4 transactions -> grants alternate LSU, IC, LSU, IC.
REQ-031 LSU len 0, rresp=2'b10 on the single beat -> ls_last_o=1, err_o pulses one cycle later, FSM returns to IDLE.
REQ-032 Icache len 3, rlast on 2nd beat -> err_o pulse, transaction ends, next request accepted normally.
REQ-033 Assert reset during DATA after beat 1 of 4 -> next cycle all outputs at reset values; subsequent rvalid_i ignored.
